// File: rtl/vctr_strm_sched.sv
// Round-robin job scheduler that shares one vector stream datapath between NUM_REQ
// requesters: programs the length, pulses start, tracks beats, and aborts stalled jobs.
module vctr_strm_sched #(
  parameter int NUM_REQ      = 2,
  parameter int LENGTH_BITS  = 10,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LENGTH_BITS-1:0] req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             job_done,
  output logic [NUM_REQ-1:0]             job_err,
  output logic                           busy,
  output logic [LENGTH_BITS-1:0]         dp_vector_length,
  output logic                           dp_start,
  output logic                           dp_soft_rst,
  input  logic                           dp_done,
  input  logic                           dp_idle,
  input  logic                           dp_out_beat
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;
  localparam logic [2:0] S_ABORT    = 3'd5;

  // Last watchdog value before expiry: the abort fires after 2**TIMEOUT_BITS-1 stalled cycles.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  logic [2:0]              r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_owner;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_done;
  logic [NUM_REQ-1:0]      r_err;
  logic                    r_busy;
  logic [LENGTH_BITS-1:0]  r_len;
  logic                    r_start;
  logic                    r_soft_rst;
  logic [LENGTH_BITS-1:0]  r_beat_cnt;
  logic [TIMEOUT_BITS-1:0] r_wdog;

  logic                    w_any;
  logic [IDX_W-1:0]        w_pick;
  logic [LENGTH_BITS-1:0]  w_pick_len;
  logic [IDX_W-1:0]        w_rr_next;
  logic                    w_expire;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any  = 1'b1;
        w_pick = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_pick_len = req_len[w_pick*LENGTH_BITS +: LENGTH_BITS];
  assign w_rr_next  = (r_owner == IDX_W'(NUM_REQ-1)) ? '0 : r_owner + IDX_W'(1);
  assign w_expire   = (r_wdog == WD_LAST) &&
                      ((r_state == S_WAIT) || ((r_state == S_RUN) && !dp_out_beat));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_len      <= '0;
      r_start    <= 1'b0;
      r_soft_rst <= 1'b0;
      r_beat_cnt <= '0;
      r_wdog     <= '0;
    end else begin
      r_start    <= 1'b0;
      r_soft_rst <= 1'b0;
      r_done     <= '0;
      r_err      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_LOAD;
            r_owner    <= w_pick;
            r_grant    <= NUM_REQ'(1) << w_pick;
            r_len      <= w_pick_len;
            r_start    <= (w_pick_len != '0);
            r_busy     <= 1'b1;
            r_beat_cnt <= '0;
            r_wdog     <= '0;
          end
        end
        S_LOAD: begin
          if (r_len == '0) begin
            r_state <= S_COMPLETE;
            r_done  <= r_grant;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_expire) begin
            r_state    <= S_ABORT;
            r_err      <= r_grant;
            r_soft_rst <= 1'b1;
          end else begin
            r_wdog <= r_wdog + TIMEOUT_BITS'(1);
            if (!dp_idle) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (dp_done && (r_beat_cnt == r_len)) begin
            r_state <= S_COMPLETE;
            r_done  <= r_grant;
          end else if (w_expire) begin
            r_state    <= S_ABORT;
            r_err      <= r_grant;
            r_soft_rst <= 1'b1;
          end else if (dp_out_beat) begin
            r_wdog <= '0;
            if (r_beat_cnt != r_len) r_beat_cnt <= r_beat_cnt + LENGTH_BITS'(1);
          end else begin
            r_wdog <= r_wdog + TIMEOUT_BITS'(1);
          end
        end
        S_COMPLETE, S_ABORT: begin
          // A zero-length job never touched the datapath, so there is no idle to wait for.
          if ((r_state == S_ABORT) || (r_len == '0) || dp_idle) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= w_rr_next;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant            = r_grant;
  assign job_done         = r_done;
  assign job_err          = r_err;
  assign busy             = r_busy;
  assign dp_vector_length = r_len;
  assign dp_start         = r_start;
  assign dp_soft_rst      = r_soft_rst;

endmodule

// File: tb/tb_vctr_strm_sched.sv
// Directed bench for vctr_strm_sched: drives a hand-scripted datapath and checks each
// grant, pulse and latency against hand-computed values.
module tb_vctr_strm_sched;

  localparam int NR = 2;
  localparam int LB = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req;
  logic [NR*LB-1:0] req_len;
  logic [NR-1:0]  grant, job_done, job_err;
  logic           busy, dp_start, dp_soft_rst;
  logic [LB-1:0]  dp_vector_length;
  logic           dp_done, dp_idle, dp_out_beat;

  int tests_run = 0;
  int tests_failed = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_srst = 0, n_overlap = 0;

  vctr_strm_sched #(.NUM_REQ(NR), .LENGTH_BITS(LB), .TIMEOUT_BITS(12)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .grant(grant), .job_done(job_done), .job_err(job_err), .busy(busy),
    .dp_vector_length(dp_vector_length), .dp_start(dp_start), .dp_soft_rst(dp_soft_rst),
    .dp_done(dp_done), .dp_idle(dp_idle), .dp_out_beat(dp_out_beat)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish (got hang, want finish)");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and tally pulse activity seen there.
  task automatic tick();
    @(negedge clk);
    if (dp_start)             n_start++;
    if (job_done != '0)       n_done++;
    if (job_err != '0)        n_err++;
    if (dp_soft_rst)          n_srst++;
    if ($countones(grant) > 1) n_overlap++;
  endtask

  task automatic clear_counts();
    n_start = 0; n_done = 0; n_err = 0; n_srst = 0; n_overlap = 0;
  endtask

  // Serve one job for requester idx as the datapath would; the grant is expected one cycle
  // after the IDLE cycle and job_done one cycle after the datapath reports completion.
  task automatic run_job(input int idx, input int len, input bit drop, input bit perturb);
    logic [NR-1:0] oh;
    int n;
    oh = NR'(1) << idx;
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    check("grant_lat", n, 1);
    check("grant", grant, oh);
    check("vlen", dp_vector_length, len);
    check("start", dp_start, (len != 0));
    if (perturb) begin
      req = '0;
      req_len[idx*LB +: LB] = LB'(len + 3);
    end
    if (len != 0) begin
      dp_idle = 1'b0;
      tick(); tick();
      dp_out_beat = 1'b1;
      repeat (len) tick();
      dp_out_beat = 1'b0;
      dp_done = 1'b1;
    end
    n = 0;
    do begin tick(); n++; end while (job_done == '0 && n < 8);
    check("done_lat", n, 1);
    check("done_owner", job_done, oh);
    check("vlen_hold", dp_vector_length, len);
    if (drop) req[idx] = 1'b0;
    dp_done = 1'b0;
    dp_idle = 1'b1;
    tick();
    check("released", {busy, grant, job_done}, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; req_len = '0;
    dp_done = 1'b0; dp_idle = 1'b1; dp_out_beat = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {grant, job_done, job_err, busy, dp_vector_length, dp_start, dp_soft_rst}, 0);
    rst = 1'b0;
    tick();

    // 1: single job of length 4 on requester 0
    clear_counts();
    req = 2'b01; req_len = {10'd0, 10'd4};
    run_job(0, 4, 1, 0);
    check("t1_starts", n_start, 1);
    check("t1_dones", n_done, 1);

    // 2: both requesting; last owner was 0 so requester 1 goes first
    clear_counts();
    req = 2'b11; req_len = {10'd5, 10'd3};
    run_job(1, 5, 0, 0);
    run_job(0, 3, 0, 0);
    run_job(1, 5, 0, 0);
    run_job(0, 3, 0, 0);
    req = '0;
    check("t2_overlap", n_overlap, 0);
    check("t2_dones", n_done, 4);

    // 3: zero-length job never starts the datapath
    clear_counts();
    req = 2'b01; req_len = {10'd0, 10'd0};
    run_job(0, 0, 1, 0);
    check("t3_starts", n_start, 0);

    // 4: stalled datapath on requester 1 gets aborted, then requester 0 is served
    clear_counts();
    req = 2'b11; req_len = {10'd7, 10'd2};
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    check("t4_grant", grant, 2'b10);
    dp_idle = 1'b0;
    n = 0;
    while (job_err == '0 && n < 5000) begin tick(); n++; end
    check("t4_wd_lat", n, 4096);
    check("t4_err", job_err, 2'b10);
    check("t4_srst", dp_soft_rst, 1);
    check("t4_no_done", job_done, 0);
    req[1] = 1'b0;
    dp_idle = 1'b1;
    tick();
    check("t4_cleared", {grant, job_err, dp_soft_rst}, 0);
    run_job(0, 2, 1, 0);
    check("t4_err_cnt", n_err, 1);
    check("t4_srst_cnt", n_srst, 1);

    // 5: reset in the middle of a 6-beat job
    clear_counts();
    req = 2'b01; req_len = {10'd0, 10'd6};
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    check("t5_grant", grant, 2'b01);
    dp_idle = 1'b0;
    tick(); tick();
    dp_out_beat = 1'b1;
    tick(); tick();
    dp_out_beat = 1'b0;
    #2 rst = 1'b1;
    #1 check("t5_async_clear",
             {grant, job_done, job_err, busy, dp_vector_length, dp_start, dp_soft_rst}, 0);
    tick(); tick();
    check("t5_no_pulses", n_done + n_err, 0);
    dp_idle = 1'b1;
    req = 2'b11; req_len = {10'd3, 10'd3};
    rst = 1'b0;
    run_job(0, 3, 1, 0);

    // 6: requester 1 drops req and changes its length mid-job
    clear_counts();
    req_len = {10'd5, 10'd0};
    run_job(1, 5, 1, 1);
    tick(); tick();
    check("t6_idle", {busy, grant}, 0);
    check("t6_dones", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
